tx_fifo_p: RTL and testbench

Buffered two-phase handshake transmitter with a parametrised data width and FIFO depth. It sits between a router output port and the remote receiver. It accepts words from the router over a two-phase req1/ack1 channel, stores up to DEPTH of them, and forwards them in order over a two-phase req2/ack2 channel. Unlike the single-register transmitter, it decouples the router from remote acknowledge latency and exposes occupancy status.

---
 rtl/tx_fifo_p_if.sv | 28 ++
 rtl/tx_fifo_p.sv | 115 +++++++++++
 tb/tb_tx_fifo_p.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/tx_fifo_p_if.sv
// Handshake bundle for tx_fifo_p: router-side req1/ack1/data1, remote-side req2/ack2/data2, plus occupancy status.
// master is the FIFO's view; slave is the partners' view.
interface tx_fifo_p_if #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic             req1;
  logic [WIDTH-1:0] data1;
  logic             ack1;
  logic             req2;
  logic [WIDTH-1:0] data2;
  logic             ack2;
  logic [CW-1:0]    count;
  logic             full;
  logic             empty;

  modport master (
    input  req1, data1, ack2,
    output ack1, req2, data2, count, full, empty
  );

  modport slave (
    output req1, data1, ack2,
    input  ack1, req2, data2, count, full, empty
  );
endinterface

// File: rtl/tx_fifo_p.sv
// Buffered two-phase handshake transmitter: DEPTH-entry FIFO between a router req1/ack1 port and a remote req2/ack2 link.
// Optional macro TX_FIFO_SYNC_EN adds 2-flop synchronizers on req1 and ack2 for partners in another clock domain.
module tx_fifo_p #(
  parameter int WIDTH    = 8,
  parameter int DEPTH    = 4,
  parameter int routerid = -1,
  parameter     port     = "unknown"
) (
  input  logic         clk,
  input  logic         reset,
  tx_fifo_p_if.master  bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return p + 1'b1;
  endfunction

  logic             req1_s;
  logic             ack2_s;
  logic             ack1_r;
  logic             req2_r;
  logic [WIDTH-1:0] data2_r;
  logic [CW-1:0]    count_r;
  logic             full_r;
  logic             empty_r;
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             push;
  logic             launch;
  logic [CW-1:0]    count_nxt;

  // Debug-only identity; keeps the parameters referenced without affecting logic.
  logic unused_dbg;
  assign unused_dbg = ^{routerid, port};

`ifdef TX_FIFO_SYNC_EN
  logic req1_p0, req1_p1, ack2_p0, ack2_p1;

  // Synchronizer stages p0 -> p1
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      req1_p0 <= 1'b0;
      req1_p1 <= 1'b0;
      ack2_p0 <= 1'b0;
      ack2_p1 <= 1'b0;
    end else begin
      req1_p0 <= bus.req1;
      req1_p1 <= req1_p0;
      ack2_p0 <= bus.ack2;
      ack2_p1 <= ack2_p0;
    end
  end

  assign req1_s = req1_p1;
  assign ack2_s = ack2_p1;
`else
  assign req1_s = bus.req1;
  assign ack2_s = bus.ack2;
`endif

  // Full/empty are start-of-cycle registered flags, so a push into a full FIFO waits even if a launch frees a slot this edge.
  assign push   = (req1_s != ack1_r) && !full_r;
  assign launch = (req2_r == ack2_s) && !empty_r;

  always_comb begin
    count_nxt = count_r;
    case ({push, launch})
      2'b10:   count_nxt = count_r + 1'b1;
      2'b01:   count_nxt = count_r - 1'b1;
      default: count_nxt = count_r;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ack1_r  <= 1'b0;
      req2_r  <= 1'b0;
      data2_r <= '0;
      count_r <= '0;
      full_r  <= 1'b0;
      empty_r <= 1'b1;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
    end else begin
      if (push) begin
        ack1_r <= ~ack1_r;
        wr_ptr <= ptr_inc(wr_ptr);
      end
      if (launch) begin
        data2_r <= mem[rd_ptr];
        req2_r  <= ~req2_r;
        rd_ptr  <= ptr_inc(rd_ptr);
      end
      count_r <= count_nxt;
      full_r  <= (count_nxt == FULL_CNT);
      empty_r <= (count_nxt == '0);
    end
  end

  // Storage carries no reset; occupancy is tracked solely by the pointers and count.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= bus.data1;
  end

  assign bus.ack1  = ack1_r;
  assign bus.req2  = req2_r;
  assign bus.data2 = data2_r;
  assign bus.count = count_r;
  assign bus.full  = full_r;
  assign bus.empty = empty_r;
endmodule

// File: tb/tb_tx_fifo_p.sv
// Directed bench for tx_fifo_p (default build, WIDTH=8, DEPTH=4): per-edge vector table plus wrap and reset sequences.
module tb_tx_fifo_p;
  logic clk = 1'b0;
  logic reset = 1'b0;
  int   nvec = 0;
  int   nmis = 0;

  always #5 clk = ~clk;

  tx_fifo_p_if #(.WIDTH(8), .DEPTH(4)) bus ();

  tx_fifo_p #(.WIDTH(8), .DEPTH(4), .routerid(3), .port("east")) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.master)
  );

  typedef struct {
    logic        req1;
    logic [7:0]  data1;
    logic        ack2;
    logic [14:0] exp;
  } vec_t;

  vec_t vecs[20];

  function automatic logic [14:0] e(input logic a1, input logic r2, input logic [7:0] d2,
                                    input logic [2:0] c, input logic f, input logic em);
    return {a1, r2, d2, c, f, em};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nmis++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic wait_ack1(input logic want, input string nm);
    int n = 0;
    while (bus.ack1 !== want && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk(nm, {31'd0, bus.ack1}, {31'd0, want});
  endtask

  task automatic wait_req2(input logic want, input string nm);
    int n = 0;
    while (bus.req2 !== want && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk(nm, {31'd0, bus.req2}, {31'd0, want});
  endtask

  logic [14:0] act;
  logic        r1;
  logic        a2;

  initial begin
    // Each vector: inputs applied at a negedge, outputs checked at the next negedge (one posedge later).
    vecs[0]  = '{1'b1, 8'hA5, 1'b0, e(1, 0, 8'h00, 3'd1, 0, 0)};
    vecs[1]  = '{1'b1, 8'hA5, 1'b0, e(1, 1, 8'hA5, 3'd0, 0, 1)};
    vecs[2]  = '{1'b1, 8'hA5, 1'b1, e(1, 1, 8'hA5, 3'd0, 0, 1)};
    vecs[3]  = '{1'b0, 8'h01, 1'b1, e(0, 1, 8'hA5, 3'd1, 0, 0)};
    vecs[4]  = '{1'b0, 8'h01, 1'b1, e(0, 0, 8'h01, 3'd0, 0, 1)};
    vecs[5]  = '{1'b1, 8'h02, 1'b1, e(1, 0, 8'h01, 3'd1, 0, 0)};
    vecs[6]  = '{1'b0, 8'h03, 1'b1, e(0, 0, 8'h01, 3'd2, 0, 0)};
    vecs[7]  = '{1'b1, 8'h04, 1'b1, e(1, 0, 8'h01, 3'd3, 0, 0)};
    vecs[8]  = '{1'b0, 8'h05, 1'b1, e(0, 0, 8'h01, 3'd4, 1, 0)};
    vecs[9]  = '{1'b1, 8'h06, 1'b1, e(0, 0, 8'h01, 3'd4, 1, 0)};
    vecs[10] = '{1'b1, 8'h06, 1'b1, e(0, 0, 8'h01, 3'd4, 1, 0)};
    vecs[11] = '{1'b1, 8'h06, 1'b0, e(0, 1, 8'h02, 3'd3, 0, 0)};
    vecs[12] = '{1'b1, 8'h06, 1'b0, e(1, 1, 8'h02, 3'd4, 1, 0)};
    vecs[13] = '{1'b1, 8'h06, 1'b1, e(1, 0, 8'h03, 3'd3, 0, 0)};
    vecs[14] = '{1'b1, 8'h06, 1'b1, e(1, 0, 8'h03, 3'd3, 0, 0)};
    vecs[15] = '{1'b1, 8'h06, 1'b0, e(1, 1, 8'h04, 3'd2, 0, 0)};
    vecs[16] = '{1'b0, 8'h07, 1'b1, e(0, 0, 8'h05, 3'd2, 0, 0)};
    vecs[17] = '{1'b0, 8'h07, 1'b0, e(0, 1, 8'h06, 3'd1, 0, 0)};
    vecs[18] = '{1'b0, 8'h07, 1'b1, e(0, 0, 8'h07, 3'd0, 0, 1)};
    vecs[19] = '{1'b0, 8'h07, 1'b1, e(0, 0, 8'h07, 3'd0, 0, 1)};

    bus.req1  = 1'b0;
    bus.data1 = 8'h00;
    bus.ack2  = 1'b0;
    repeat (3) @(negedge clk);
    act = {bus.ack1, bus.req2, bus.data2, bus.count, bus.full, bus.empty};
    chk("reset_state", act, e(0, 0, 8'h00, 3'd0, 0, 1));
    reset = 1'b1;
    @(negedge clk);
    act = {bus.ack1, bus.req2, bus.data2, bus.count, bus.full, bus.empty};
    chk("idle_after_release", act, e(0, 0, 8'h00, 3'd0, 0, 1));

    for (int i = 0; i < 20; i++) begin
      bus.req1  = vecs[i].req1;
      bus.data1 = vecs[i].data1;
      bus.ack2  = vecs[i].ack2;
      @(negedge clk);
      act = {bus.ack1, bus.req2, bus.data2, bus.count, bus.full, bus.empty};
      chk($sformatf("vec%0d", i), act, vecs[i].exp);
    end

    // Complete the outstanding word 07, then stream 10 words through the wrapping pointers.
    a2 = 1'b0;
    r1 = 1'b0;
    bus.ack2 = a2;
    @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      r1 = ~r1;
      bus.req1  = r1;
      bus.data1 = 8'h10 + 8'(i);
      wait_ack1(r1, $sformatf("wrap_ack1_%0d", i));
      wait_req2(~a2, $sformatf("wrap_req2_%0d", i));
      chk($sformatf("wrap_data_%0d", i), {24'd0, bus.data2}, {24'd0, 8'h10 + 8'(i)});
      a2 = ~a2;
      bus.ack2 = a2;
      @(negedge clk);
    end
    chk("wrap_empty", {29'd0, bus.count, bus.empty}, 32'd1);

    // Build count=3 with the remote stalled, then reset mid-burst.
    for (int k = 0; k < 4; k++) begin
      r1 = ~r1;
      bus.req1  = r1;
      bus.data1 = 8'h30 + 8'(k);
      wait_ack1(r1, $sformatf("burst_ack1_%0d", k));
      @(negedge clk);
    end
    chk("burst_count", {29'd0, bus.count}, 32'd3);
    chk("burst_data2", {24'd0, bus.data2}, 32'h30);
    reset = 1'b0;
    #1;
    act = {bus.ack1, bus.req2, bus.data2, bus.count, bus.full, bus.empty};
    chk("async_reset", act, e(0, 0, 8'h00, 3'd0, 0, 1));
    bus.req1 = 1'b0;
    bus.ack2 = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    act = {bus.ack1, bus.req2, bus.data2, bus.count, bus.full, bus.empty};
    chk("no_launch_after_reset", act, e(0, 0, 8'h00, 3'd0, 0, 1));

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running want finished");
    $fatal(1, "timeout");
  end
endmodule
